// File: rtl/rng_uni_pkg.sv
// rng_uni_pkg: shared lane geometry, feedback tap table, default seed and feedback helper
package rng_uni_pkg;
  localparam int RNG_UNI_LANES = 32;
  localparam int RNG_UNI_LANE_W = 32;
  localparam int RNG_UNI_STATE_W = RNG_UNI_LANES * RNG_UNI_LANE_W;
  localparam int RNG_UNI_TAP_OFF [4] = '{1, 5, 11, 23};
  localparam int RNG_UNI_TAP_BIT [4] = '{0, 7, 17, 29};
  localparam logic [RNG_UNI_STATE_W-1:0] RNG_UNI_DEFAULT_SEED = {RNG_UNI_LANES{32'h6A09E667}};
  typedef logic [RNG_UNI_LANE_W-1:0] lane_t;
  function automatic logic rng_uni_fb(input logic [RNG_UNI_STATE_W-1:0] s, input int lane);
    logic f;
    f = 1'b0;
    for (int k = 0; k < 4; k++)
      f ^= s[RNG_UNI_LANE_W * ((lane + RNG_UNI_TAP_OFF[k]) % RNG_UNI_LANES) + RNG_UNI_TAP_BIT[k]];
    return f;
  endfunction
endpackage

// File: rtl/rng_uni_lane.sv
// rng_uni_lane: 32-bit right-shift lane whose top bit comes from the scan chain or the XOR feedback
module rng_uni_lane
  import rng_uni_pkg::*;
#(
  parameter lane_t INIT = '0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ce,
  input  logic  mode,
  input  logic  ser_in,
  input  logic  fb_in,
  output lane_t q
);
  // shift right each enabled edge; the top bit is the only thing the mode selects
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT;
    else if (ce) q <= {mode ? ser_in : fb_in, q[RNG_UNI_LANE_W-1:1]};
endmodule

// File: rtl/rng_uni_core.sv
// rng_uni_core: 1024-bit 32-lane shift-register uniform RNG with serial seeding (s_out driven when RNG_UNI_SOUT_EN is defined)
module rng_uni_core
  import rng_uni_pkg::*;
#(
  parameter logic [RNG_UNI_STATE_W-1:0] SEED = RNG_UNI_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        mode,
  input  logic        s_in,
  output logic        s_out,
  output logic [31:0] rng
);
  logic [RNG_UNI_STATE_W-1:0] state;
  for (genvar i = 0; i < RNG_UNI_LANES; i++) begin : g_lane
    rng_uni_lane #(.INIT(SEED[RNG_UNI_LANE_W*i +: RNG_UNI_LANE_W])) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .mode  (mode),
      .ser_in(i == RNG_UNI_LANES - 1 ? s_in : state[(RNG_UNI_LANE_W*i + RNG_UNI_LANE_W) % RNG_UNI_STATE_W]),
      .fb_in (rng_uni_fb(state, i)),
      .q     (state[RNG_UNI_LANE_W*i +: RNG_UNI_LANE_W])
    );
    assign rng[i] = state[RNG_UNI_LANE_W*i];
  end
`ifdef RNG_UNI_SOUT_EN
  assign s_out = state[0];
`else
  assign s_out = 1'b0;
`endif
endmodule

// File: tb/tb_rng_uni_core.sv
// tb_rng_uni_core: directed vectors and multi-cycle sequences for rng_uni_core
module tb_rng_uni_core;
  localparam logic [1023:0] SEED0 = {32{32'h6A09E667}};
  logic clk = 1'b0;
  logic rst, ce, mode, s_in, s_out;
  logic [31:0] rng;
  logic [1023:0] m;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    string       nm;
    logic [31:0] lane;
    int          gens;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  rng_uni_core dut (.clk(clk), .rst(rst), .ce(ce), .mode(mode), .s_in(s_in), .s_out(s_out), .rng(rng));

  always #5 clk = ~clk;

  function automatic logic [1023:0] gen_next(input logic [1023:0] s);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) begin
      r[32*i+31] = s[32*((i+1)%32)] ^ s[32*((i+5)%32)+7] ^ s[32*((i+11)%32)+17] ^ s[32*((i+23)%32)+29];
      r[32*i +: 31] = s[32*i+1 +: 31];
    end
    return r;
  endfunction

  function automatic logic [31:0] rng_of(input logic [1023:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[32*i];
    return r;
  endfunction

  function automatic logic sout_exp(input logic [1023:0] s);
`ifdef RNG_UNI_SOUT_EN
    return s[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_rng"}, rng, rng_of(m));
    chk({nm, "_sout"}, {31'd0, s_out}, {31'd0, sout_exp(m)});
  endtask

  task automatic tick();
    logic [1023:0] nx;
    nx = m;
    if (!rst && ce) nx = mode ? {s_in, m[1023:1]} : gen_next(m);
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic load(input logic [1023:0] w, input logic replay);
    ce = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 1024; k++) begin
`ifdef RNG_UNI_SOUT_EN
      if (replay) chk("sout_replay", {31'd0, s_out}, {31'd0, SEED0[k]});
`endif
      s_in = w[k];
      tick();
    end
  endtask

  task automatic gen(input int n);
    ce = 1'b1;
    mode = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m = SEED0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1023:0] pat;
    logic [31:0] held;
    tbl[0] = '{"lane1_g0",   32'h00000001, 0, 32'hFFFFFFFF};
    tbl[1] = '{"lane1_g1",   32'h00000001, 1, 32'h00000000};
    tbl[2] = '{"lane2_g1",   32'h00000002, 1, 32'hFFFFFFFF};
    tbl[3] = '{"lane0_g5",   32'h00000000, 5, 32'h00000000};
    tbl[4] = '{"lane4_g2",   32'h00000004, 2, 32'hFFFFFFFF};
    tbl[5] = '{"lane80_g1",  32'h00000080, 1, 32'h00000000};
    tbl[6] = '{"lane80_g7",  32'h00000080, 7, 32'hFFFFFFFF};
    tbl[7] = '{"lane100_g7", 32'h00000100, 7, 32'h00000000};
    rst = 1'b1;
    ce = 1'b0;
    mode = 1'b0;
    s_in = 1'b0;
    m = SEED0;
    #2;
    chk("reset_rng", rng, 32'hFFFFFFFF);
    chk("reset_sout", {31'd0, s_out}, {31'd0, sout_exp(SEED0)});
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen(1);
    chk("seed_gen1", rng, 32'hFFFFFFFF);
    chk_model("seed_gen1_model");
    gen(2);
    chk("seed_gen3", rng, 32'h00000000);
    for (int c = 0; c < 40; c++) begin
      gen(1);
      chk_model("seed_run");
    end
    do_reset();
    for (int i = 0; i < 32; i++) pat[32*i +: 32] = i;
    load(pat, 1'b1);
    chk("load_lane_idx", rng, 32'hAAAAAAAA);
    chk_model("load_lane_idx_model");
    for (int c = 0; c < 64; c++) begin
      gen(1);
      chk_model("lane_idx_run");
    end
    for (int t = 0; t < 8; t++) begin
      load({32{tbl[t].lane}}, 1'b0);
      gen(tbl[t].gens);
      chk(tbl[t].nm, rng, tbl[t].exp);
    end
    load(1024'h1, 1'b0);
    chk("onebit_load", rng, 32'h00000001);
    gen(1);
    chk("onebit_gen1", rng, 32'h00000000);
    chk("onebit_l31b31", {31'd0, dut.state[1023]}, 32'd1);
    load('0, 1'b0);
    chk("zero_load", rng, 32'h00000000);
    for (int c = 0; c < 1000; c++) begin
      gen(1);
      chk("zero_run", rng, 32'h00000000);
    end
    do_reset();
    for (int i = 0; i < 32; i++) pat[32*i +: 32] = 32'h9E3779B1 * (i + 3);
    ce = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      if (k == 500) begin
        held = rng;
        ce = 1'b0;
        for (int z = 0; z < 5; z++) begin
          s_in = ~s_in;
          mode = z[0];
          tick();
          chk("ce_load_frozen", rng, held);
        end
        ce = 1'b1;
        mode = 1'b1;
      end
      s_in = pat[k];
      tick();
    end
    chk("ce_load_done", rng, rng_of(pat));
    chk_model("ce_load_model");
    gen(10);
    held = rng;
    ce = 1'b0;
    for (int z = 0; z < 5; z++) begin
      tick();
      chk("ce_gen_frozen", rng, held);
    end
    for (int c = 0; c < 20; c++) begin
      gen(1);
      chk_model("ce_gen_resume");
    end
    ce = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      s_in = 1'b0;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mid_load_reset", rng, 32'hFFFFFFFF);
    m = SEED0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen(3);
    chk("after_reset_gen3", rng, 32'h00000000);
    chk_model("after_reset_model");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rng_uni_core.md
# rng_uni_core

Uniform 32-bit pseudo-random number generator built from a 1024-bit LUT-shift-register style state: 32 lanes of 32-bit shift registers with XOR feedback. The state is seeded by shifting 1024 bits through a serial scan chain, after which the block emits one fresh 32-bit uniform word per enabled cycle. It sits at the front of the sampling datapath and feeds downstream distribution transforms.

## Interface
- One clock; reset is asynchronous and active-high.
- `SEED`, default `RNG_UNI_DEFAULT_SEED` (lane value 32'h6A09E667 replicated ×32): 1024-bit state loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `ce`  in  1  clock enable; 0 freezes all state.
- `mode`  in  1  1 = serial load, 0 = generate.
- `s_in`  in  1  serial seed input bit.
- `s_out`  out  1  serial chain output (`state[0]`).
- `rng`  out  32  uniform random word.

## Operation
- State: `state[1023:0]`; lane i (0..31) = `state[32i+31 : 32i]`, bit j of lane i = `L[i][j]`.
- Reset: `state <= SEED`, asynchronously, regardless of `ce`/`mode`.
- `ce=0`: state holds; outputs static.
- Load (`ce=1, mode=1`): `state <= {s_in, state[1023:1]}`, a single 1024-bit chain across lanes. The first bit shifted in ends at `state[0]` after 1024 cycles, so shifting word W LSB-first loads `state == W` exactly.
- Generate (`ce=1, mode=0`): every lane shifts right independently, `L[i] <= {f_i, L[i][31:1]}`, with `f_i = L[(i+1)%32][0] ^ L[(i+5)%32][7] ^ L[(i+11)%32][17] ^ L[(i+23)%32][29]`. All lanes use pre-update values.
- `rng[i] = L[i][0] = state[32i]`; this is combinational from the state registers.
- The all-zero state is a fixed point. Loading zero yields `rng=0` permanently; this is documented, not guarded.
- `mode` may change on any cycle. The next edge uses the new mode, with no flush.

## Timing
- `rng` and `s_out` are valid immediately after any state edge; latency 0 from state.
- Each generate edge produces a new `rng` word visible after that edge; throughput 1 word/cycle.
- Full seeding takes exactly 1024 load cycles with `ce=1`. Cycles with `ce=0` are not counted.
- Reset outputs: `rng = 32'hFFFFFFFF` (bit 0 of 32'h6A09E667 is 1 in every lane), `s_out = 1`.
- Reset asserted mid-load or mid-generate restores `SEED` at once. A partial load is discarded.

## Configuration
- `RNG_UNI_SOUT_EN`
  - Defined: `s_out = state[0]`, allowing chained seeding of multiple instances.
  - Undefined: `s_out` is tied to 0. The port remains.

## Structure
- Shared package `rng_uni_pkg`:
  - `RNG_UNI_LANES=32`, `RNG_UNI_LANE_W=32`
  - tap table: lane offsets {1,5,11,23}, bit positions {0,7,17,29}
  - `RNG_UNI_DEFAULT_SEED`
  - lane typedef
- One natural sub-module, `rng_uni_lane`: a 32-bit shift register with a mux between the serial-chain input and the feedback input, instantiated 32×.

## Test plan
- Reset: assert `rst` → `rng=32'hFFFFFFFF` and `s_out=1`. Hold `ce=1, mode=0` for one edge → `rng` equals the value predicted by the tap equations from `SEED`.
- Serial load: shift a known 1024-bit pattern LSB-first over 1024 cycles with `ce=1, mode=1` → `state` equals the pattern and `rng[i]` equals pattern bit 32i. With `RNG_UNI_SOUT_EN`, `s_out` replays the `SEED` bits 0..1023 in order.
- Single-bit load: load only bit 0 = 1 → `rng=32'h00000001`. After one generate cycle → `rng=32'h00000000`, and `L[31][31]=1`.
- Zero seed: load all zeros, then generate 1000 cycles → `rng=0` every cycle.
- ce gating: toggle `ce=0` for 5 cycles mid-load and mid-generate → state frozen, and the load completes after exactly 1024 enabled cycles.
- Statistics/model check: load the team's standard seed, generate 4,000,000 words, compare bit-exactly against the C reference model; each output bit mean within 0.5 ± 0.001.
